// File: rtl/disp_mux.sv
// Two-digit common-anode seven-segment multiplexer: alternates d0/d1 onto s with active-low digit enables.
// Optional dead time between digits is built when DISP_MUX_DEADTIME_EN is defined.
module disp_mux #(
    parameter int ON_CYCLES    = 10000,
    parameter int BLANK_CYCLES = 100,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    output logic [3:0] s,
    output logic [1:0] an_n,
    output logic       sel
);

    // Reject configurations the phase counter cannot express.
    if (ON_CYCLES < 1 || BLANK_CYCLES < 1 ||
        longint'(ON_CYCLES) > (longint'(1) << CNT_W) ||
        longint'(BLANK_CYCLES) > (longint'(1) << CNT_W)) begin : g_bad_cfg
        $error("disp_mux: invalid ON_CYCLES/BLANK_CYCLES/CNT_W combination");
    end

    localparam logic [CNT_W-1:0] ON_LAST = CNT_W'(ON_CYCLES - 1);
    localparam logic [1:0]       AN_OFF  = 2'b11;
    localparam logic [1:0]       AN_DIG0 = 2'b10;
    localparam logic [1:0]       AN_DIG1 = 2'b01;

`ifdef DISP_MUX_DEADTIME_EN
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        DIG0   = 2'd0,
        BLANK0 = 2'd1,
        DIG1   = 2'd2,
        BLANK1 = 2'd3
    } state_t;

    // Reset and a disabled display both park here; the normal exit leads into DIG0.
    localparam state_t REST = BLANK1;
`else
    typedef enum logic [1:0] {
        OFF  = 2'd0,
        DIG0 = 2'd1,
        DIG1 = 2'd2
    } state_t;

    localparam state_t REST = OFF;
`endif

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       s_nxt;
    logic [1:0]       an_nxt;
    logic             sel_nxt;

    // Outputs are computed for the state being entered and registered with it,
    // so s and an_n always change on the same edge.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        s_nxt     = s;
        an_nxt    = an_n;
        sel_nxt   = sel;

        if (!reset) begin
            state_nxt = REST;
            cnt_nxt   = '0;
            s_nxt     = 4'h0;
            an_nxt    = AN_OFF;
            sel_nxt   = 1'b0;
        end else if (!en) begin
            state_nxt = REST;
            cnt_nxt   = '0;
            an_nxt    = AN_OFF;
            sel_nxt   = 1'b0;
        end else begin
            unique case (state)
`ifdef DISP_MUX_DEADTIME_EN
                DIG0: begin
                    if (cnt == ON_LAST) begin
                        state_nxt = BLANK0;
                        cnt_nxt   = '0;
                        an_nxt    = AN_OFF;
                        sel_nxt   = 1'b0;
                    end
                end
                BLANK0: begin
                    if (cnt == BLANK_LAST) begin
                        state_nxt = DIG1;
                        cnt_nxt   = '0;
                        s_nxt     = d1;
                        an_nxt    = AN_DIG1;
                        sel_nxt   = 1'b1;
                    end
                end
                DIG1: begin
                    if (cnt == ON_LAST) begin
                        state_nxt = BLANK1;
                        cnt_nxt   = '0;
                        an_nxt    = AN_OFF;
                        sel_nxt   = 1'b0;
                    end
                end
                BLANK1: begin
                    if (cnt == BLANK_LAST) begin
                        state_nxt = DIG0;
                        cnt_nxt   = '0;
                        s_nxt     = d0;
                        an_nxt    = AN_DIG0;
                        sel_nxt   = 1'b0;
                    end
                end
`else
                OFF: begin
                    state_nxt = DIG0;
                    cnt_nxt   = '0;
                    s_nxt     = d0;
                    an_nxt    = AN_DIG0;
                    sel_nxt   = 1'b0;
                end
                DIG0: begin
                    if (cnt == ON_LAST) begin
                        state_nxt = DIG1;
                        cnt_nxt   = '0;
                        s_nxt     = d1;
                        an_nxt    = AN_DIG1;
                        sel_nxt   = 1'b1;
                    end
                end
                DIG1: begin
                    if (cnt == ON_LAST) begin
                        state_nxt = DIG0;
                        cnt_nxt   = '0;
                        s_nxt     = d0;
                        an_nxt    = AN_DIG0;
                        sel_nxt   = 1'b0;
                    end
                end
`endif
                default: begin
                    state_nxt = REST;
                    cnt_nxt   = '0;
                    an_nxt    = AN_OFF;
                    sel_nxt   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
        s     <= s_nxt;
        an_n  <= an_nxt;
        sel   <= sel_nxt;
    end

endmodule
